mm_rd_frame: RTL and testbench
==============================

// Module: mm_rd_frame
// PURPOSE
//  AXI4 memory-mapped read master: fetches one frame of AXI_DSIZE-bit words from DDR and
//  replays it as an AXI4-Stream video stream (tuser=SOF, tlast=EOL). Read-side counterpart
//  of mm_tras in the VDMA path; feeds the pixel-domain unpacker through a stream CDC FIFO.
//  Bursts issue only when the internal FIFO has reserved space, so the R channel never stalls.
// PARAMETERS
//  ASIZE       29   AXI address width (byte address)
//  LSIZE       9    arlen port width (AXI4 uses [7:0]; upper bits tied 0)
//  DSIZE       256  AXI data / stream data width; power of 2, >= 32
//  IDSIZE      4    AXI ID width
//  ID          0    constant driven on axi_arid; axi_rid must match
//  BURST_MAX   128  max beats per burst, 1..256
//  FIFO_DEPTH  512  internal buffer depth in words, power of 2, >= 2*BURST_MAX
// PORTS
//  clock        in   1          AXI + stream clock
//  rst          in   1          synchronous, active-high reset
//  start        in   1          1-cycle pulse: begin frame read (ignored while busy)
//  base_addr    in   ASIZE      frame start byte address, DSIZE/8-aligned; sampled on start
//  frame_words  in   24         beats per frame (>=1); sampled on start
//  line_words   in   16         beats per video line (>=1); sampled on start
//  busy         out  1          high from start acceptance until done
//  done         out  1          1-cycle pulse: last beat accepted on stream
//  error        out  1          sticky: rresp!=OKAY, rid!=ID or rlast misplaced; cleared on start
//  axi_arid     out  IDSIZE     = ID
//  axi_araddr   out  ASIZE      burst start address
//  axi_arlen    out  LSIZE      beats-1
//  axi_arsize   out  3          log2(DSIZE/8)
//  axi_arburst  out  2          2'b01 INCR
//  axi_arvalid  out  1          AR valid
//  axi_arready  in   1          AR ready
//  axi_rid      in   IDSIZE     read ID
//  axi_rdata    in   DSIZE      read data
//  axi_rresp    in   2          read response
//  axi_rlast    in   1          last beat of burst
//  axi_rvalid   in   1          R valid
//  axi_rready   out  1          R ready
//  axis_tdata   out  DSIZE      stream data
//  axis_tvalid  out  1          stream valid
//  axis_tready  in   1          stream ready
//  axis_tuser   out  1          first beat of frame
//  axis_tlast   out  1          last beat of each line
// BEHAVIOUR
//  Reset: all outputs 0 except arid=ID, arsize, arburst (constants); FIFO flushed,
//   counters 0, FSM IDLE. Reset mid-frame abandons outstanding bursts; system resets
//   interconnect together with this block.
//  FSM IDLE->REQ on start (latch inputs, busy=1, error=0). REQ: beats = min(BURST_MAX,
//   remaining, words left to next 4KB boundary); stays in REQ while
//   FIFO_DEPTH - fifo_count - reserved < beats; else reserve beats, ->ADDR.
//  ADDR: arvalid=1, addr/len stable until arready; on handshake addr += beats*DSIZE/8,
//   remaining -= beats; remaining>0 ->REQ else ->DRAIN. arvalid first high 2 cycles
//   after start.
//  DRAIN: wait all requested beats received and stream count = frame_words -> done pulse,
//   busy=0, ->IDLE. Multiple outstanding bursts allowed (bounded by reservation).
//  R: rready=1 whenever busy. Each accepted beat writes FIFO, reserved -= 1. rlast checked
//   against per-burst beat count in AR order; mismatch, rresp!=0 or rid!=ID sets error;
//   data still forwarded, beat counting continues unchanged.
//  Stream: first-word-fall-through; tvalid earliest 1 cycle after R beat accepted.
//   tdata/tuser/tlast held while tvalid & !tready. tuser=1 on beat 0 of frame; line
//   counter +1 per stream beat, tlast when count = line_words-1, then wraps to 0; last
//   frame beat forces tlast=1 even if line incomplete.
//  Simultaneous FIFO write and read: count unchanged. FIFO never overflows by construction;
//   overflow attempt is an assertion failure in simulation.
//  start while busy: ignored, no effect on latched parameters.
// TESTING
//  base 0, frame 1920*1080/8 words, line 240, tready=1 -> 8100 bursts of 32?no: bursts of
//   128, data = memory image, 1080 tlast, 1 tuser, done once, error 0.
//  base 0xF80, frame 10, BURST_MAX 128 -> AR len 3 @0xF80 (to 4KB), then len 5 @0x1000.
//  tready held 0 after start, frame 2048 -> ARs stop when 512 words reserved; rready never
//   drops; release tready -> remaining bursts issue, all data in order.
//  rresp=2'b10 on beat 5 -> error=1 after that beat, stream still delivers all words,
//   done pulses; next start clears error.
//  rlast early on beat 62 of 128-beat burst -> error=1; frame_words beats still counted.
//  rst asserted mid-burst -> next cycle all outputs reset; new start re-reads from base_addr.

Source files
------------

// File: rtl/mm_rd_frame.sv
// AXI4 read master that fetches one frame of DSIZE-bit words from memory and replays it
// as an AXI4-Stream video stream (tuser = start of frame, tlast = end of line).
module mm_rd_frame #(
    parameter int ASIZE      = 29,
    parameter int LSIZE      = 9,
    parameter int DSIZE      = 256,
    parameter int IDSIZE     = 4,
    parameter int ID         = 0,
    parameter int BURST_MAX  = 128,
    parameter int FIFO_DEPTH = 512
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [ASIZE-1:0]  base_addr,
    input  logic [23:0]       frame_words,
    input  logic [15:0]       line_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDSIZE-1:0] axi_arid,
    output logic [ASIZE-1:0]  axi_araddr,
    output logic [LSIZE-1:0]  axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [IDSIZE-1:0] axi_rid,
    input  logic [DSIZE-1:0]  axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    output logic [DSIZE-1:0]  axis_tdata,
    output logic              axis_tvalid,
    input  logic              axis_tready,
    output logic              axis_tuser,
    output logic              axis_tlast
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int BSH   = $clog2(DSIZE / 8);
    localparam int LQ_AW = 4;
    localparam int LQC   = LQ_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             arvalid_q, arvalid_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [LSIZE-1:0] arlen_q, arlen_d;
    logic [8:0]       beats_q, beats_d;
    logic [23:0]      rem_q, rem_d, frame_q, frame_d, out_cnt_q, out_cnt_d;
    logic [15:0]      line_q, line_d, line_cnt_q, line_cnt_d;
    logic [CW-1:0]    rsv_q, rsv_d, cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LQ_AW-1:0] lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    logic [LQC-1:0]   lq_cnt_q, lq_cnt_d;
    logic [7:0]       rbeat_q, rbeat_d;

    logic [DSIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [7:0]       lq_mem [2**LQ_AW];

    logic             r_fire, s_fire, ar_fire, lq_push, lq_pop, exp_last, room;
    logic [12:0]      to4k_w;
    logic [23:0]      beats_w;
    logic [CW:0]      free_w;

    assign axi_arid    = IDSIZE'(ID);
    assign axi_arsize  = 3'(BSH);
    assign axi_arburst = 2'b01;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

    assign axis_tvalid = (cnt_q != '0);
    assign axis_tdata  = axis_tvalid ? fifo_mem[rd_ptr_q] : '0;
    assign axis_tuser  = axis_tvalid && (out_cnt_q == 24'd0);
    assign axis_tlast  = axis_tvalid && ((line_cnt_q == line_q - 16'd1) ||
                                         (out_cnt_q == frame_q - 24'd1));

    assign r_fire  = axi_rvalid && busy_q;
    assign s_fire  = axis_tvalid && axis_tready;
    assign ar_fire = arvalid_q && axi_arready;

    // Burst size is clipped so no burst ever crosses a 4KB page
    assign to4k_w = (13'h1000 - {1'b0, addr_q[11:0]}) >> BSH;
    assign free_w = (CW+1)'(FIFO_DEPTH) - {1'b0, cnt_q} - {1'b0, rsv_q};
    assign room   = (24'(free_w) >= beats_w) && (lq_cnt_q != LQC'(2**LQ_AW));
    assign exp_last = (lq_cnt_q != '0) && (rbeat_q == lq_mem[lq_rd_q]);

    always_comb begin
        beats_w = rem_q;
        if (24'(BURST_MAX) < beats_w) beats_w = 24'(BURST_MAX);
        if (24'(to4k_w) < beats_w)    beats_w = 24'(to4k_w);
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        arvalid_d  = arvalid_q;
        addr_d     = addr_q;
        arlen_d    = arlen_q;
        beats_d    = beats_q;
        rem_d      = rem_q;
        frame_d    = frame_q;
        line_d     = line_q;
        rsv_d      = rsv_q - CW'(r_fire);
        cnt_d      = cnt_q + CW'(r_fire) - CW'(s_fire);
        wr_ptr_d   = wr_ptr_q + AW'(r_fire);
        rd_ptr_d   = rd_ptr_q + AW'(s_fire);
        out_cnt_d  = out_cnt_q;
        line_cnt_d = line_cnt_q;
        lq_wr_d    = lq_wr_q;
        lq_rd_d    = lq_rd_q;
        rbeat_d    = rbeat_q;
        lq_push    = 1'b0;
        lq_pop     = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                addr_d     = base_addr;
                rem_d      = frame_words;
                frame_d    = frame_words;
                line_d     = line_words;
                busy_d     = 1'b1;
                error_d    = 1'b0;
                out_cnt_d  = '0;
                line_cnt_d = '0;
                state_d    = S_REQ;
            end
            S_REQ: if (room) begin
                rsv_d     = rsv_q - CW'(r_fire) + CW'(beats_w);
                beats_d   = beats_w[8:0];
                arlen_d   = LSIZE'(beats_w - 24'd1);
                arvalid_d = 1'b1;
                state_d   = S_ADDR;
            end
            S_ADDR: if (ar_fire) begin
                arvalid_d = 1'b0;
                addr_d    = addr_q + (ASIZE'(beats_q) << BSH);
                rem_d     = rem_q - 24'(beats_q);
                lq_push   = 1'b1;
                lq_wr_d   = lq_wr_q + LQ_AW'(1);
                state_d   = (rem_d != 24'd0) ? S_REQ : S_DRAIN;
            end
            S_DRAIN: if (rsv_q == '0 && out_cnt_q == frame_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Beat counting follows the AR lengths, never the slave's rlast
        if (r_fire) begin
            if ((axi_rlast != exp_last) || (axi_rresp != 2'b00) ||
                (axi_rid != IDSIZE'(ID)) || (lq_cnt_q == '0)) begin
                error_d = 1'b1;
            end
            if (exp_last) begin
                lq_pop  = 1'b1;
                lq_rd_d = lq_rd_q + LQ_AW'(1);
                rbeat_d = '0;
            end else begin
                rbeat_d = rbeat_q + 8'd1;
            end
        end

        if (s_fire) begin
            out_cnt_d  = out_cnt_q + 24'd1;
            line_cnt_d = (line_cnt_q == line_q - 16'd1) ? 16'd0 : line_cnt_q + 16'd1;
        end

        lq_cnt_d = lq_cnt_q + LQC'(lq_push) - LQC'(lq_pop);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            arvalid_q  <= 1'b0;
            addr_q     <= '0;
            arlen_q    <= '0;
            beats_q    <= '0;
            rem_q      <= '0;
            frame_q    <= '0;
            line_q     <= '0;
            rsv_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_cnt_q  <= '0;
            line_cnt_q <= '0;
            lq_wr_q    <= '0;
            lq_rd_q    <= '0;
            lq_cnt_q   <= '0;
            rbeat_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            arvalid_q  <= arvalid_d;
            addr_q     <= addr_d;
            arlen_q    <= arlen_d;
            beats_q    <= beats_d;
            rem_q      <= rem_d;
            frame_q    <= frame_d;
            line_q     <= line_d;
            rsv_q      <= rsv_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_cnt_q  <= out_cnt_d;
            line_cnt_q <= line_cnt_d;
            lq_wr_q    <= lq_wr_d;
            lq_rd_q    <= lq_rd_d;
            lq_cnt_q   <= lq_cnt_d;
            rbeat_q    <= rbeat_d;
        end
    end

    always_ff @(posedge clock) begin
        if (r_fire) fifo_mem[wr_ptr_q] <= axi_rdata;
        if (lq_push) lq_mem[lq_wr_q] <= 8'(beats_q - 9'd1);
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            assert (!(r_fire && !s_fire && cnt_q == CW'(FIFO_DEPTH)));
        end
    end
endmodule

// File: tb/tb_mm_rd_frame.sv
// Scoreboard bench for mm_rd_frame: AXI read slave model, stream monitor, directed frames.
module tb_mm_rd_frame;
    logic         clock = 1'b0;
    logic         rst;
    logic         start;
    logic [28:0]  base_addr;
    logic [23:0]  frame_words;
    logic [15:0]  line_words;
    logic         busy, done, error;
    logic [3:0]   axi_arid;
    logic [28:0]  axi_araddr;
    logic [8:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_arvalid, axi_arready;
    logic [3:0]   axi_rid;
    logic [255:0] axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast, axi_rvalid, axi_rready;
    logic [255:0] axis_tdata;
    logic         axis_tvalid, axis_tready, axis_tuser, axis_tlast;

    mm_rd_frame dut (
        .clock(clock), .rst(rst), .start(start), .base_addr(base_addr),
        .frame_words(frame_words), .line_words(line_words),
        .busy(busy), .done(done), .error(error),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
        .axis_tuser(axis_tuser), .axis_tlast(axis_tlast)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [28:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed { logic [255:0] d; logic u; logic l; } s_t;

    ar_t exp_ar[$];
    ar_t slv_q[$];
    s_t  exp_s[$];

    int n_chk = 0, n_pass = 0;
    int done_cnt = 0, rready_drop = 0, n_ar = 0, r_total = 0;
    int frame_beat = 0, err_beat = -1, early_last = -1, rgap = 0, tready_mode = 0;
    logic chk_err_next = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [255:0] word_of(input int unsigned w);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = (w * 8 + k) ^ 32'h5A00_0000;
        return r;
    endfunction

    function automatic void push_frame(input logic [28:0] b, input int f, input int l);
        s_t e;
        for (int i = 0; i < f; i++) begin
            e.d = word_of((32'(b) >> 5) + i);
            e.u = (i == 0);
            e.l = ((i % l) == l - 1) || (i == f - 1);
            exp_s.push_back(e);
        end
    endfunction

    function automatic void push_ar_model(input int unsigned b, input int f);
        int unsigned a = b;
        int rem = f, bt, t4;
        ar_t e;
        while (rem > 0) begin
            t4 = (4096 - (a % 4096)) / 32;
            bt = (rem < 128) ? rem : 128;
            if (t4 < bt) bt = t4;
            e.addr = a[28:0];
            e.len  = 8'(bt - 1);
            exp_ar.push_back(e);
            a   += bt * 32;
            rem -= bt;
        end
    endfunction

    // AXI read slave: checks each AR against exp_ar, returns beats from a fixed memory image
    initial begin : r_slave
        ar_t e, cur;
        logic ar_hs, r_hs;
        int beat = 0, cyc = 0;
        int unsigned wa;
        axi_arready = 1'b1; axi_rvalid = 1'b0; axi_rlast = 1'b0;
        axi_rdata = '0; axi_rresp = 2'b00; axi_rid = 4'd0;
        forever begin
            @(negedge clock);
            if (chk_err_next) begin
                chk("error_after_bad_beat", error, 1);
                chk_err_next = 1'b0;
            end
            if (rst) begin
                slv_q.delete();
                axi_rvalid = 1'b0; axi_rlast = 1'b0;
                beat = 0;
                continue;
            end
            ar_hs = axi_arvalid && axi_arready;
            r_hs  = axi_rvalid && axi_rready;
            if (ar_hs) begin
                n_ar++;
                cur.addr = axi_araddr;
                cur.len  = axi_arlen[7:0];
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    e = exp_ar.pop_front();
                    chk("araddr", axi_araddr, e.addr);
                    chk("arlen", axi_arlen, {1'b0, e.len});
                end
                slv_q.push_back(cur);
            end
            @(posedge clock); #1;
            cyc++;
            if (r_hs && slv_q.size() > 0) begin
                if (frame_beat == err_beat) chk_err_next = 1'b1;
                frame_beat++;
                r_total++;
                if (beat == int'(slv_q[0].len)) begin
                    void'(slv_q.pop_front());
                    beat = 0;
                end else beat++;
            end
            if (slv_q.size() > 0 && !(rgap != 0 && (cyc % 5) == 0)) begin
                wa = (32'(slv_q[0].addr) >> 5) + beat;
                axi_rvalid = 1'b1;
                axi_rdata  = word_of(wa);
                axi_rresp  = (frame_beat == err_beat) ? 2'b10 : 2'b00;
                axi_rlast  = (early_last >= 0) ? (beat == early_last) : (beat == int'(slv_q[0].len));
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
            end
        end
    end

    initial begin : t_drv
        int tcyc = 0;
        axis_tready = 1'b1;
        forever begin
            @(posedge clock); #1;
            tcyc++;
            case (tready_mode)
                0:       axis_tready = 1'b1;
                1:       axis_tready = ((tcyc % 3) != 0);
                default: axis_tready = 1'b0;
            endcase
        end
    end

    // Stream monitor: pops the scoreboard on every accepted stream beat
    initial begin : s_mon
        s_t e;
        forever begin
            @(negedge clock);
            if (rst) continue;
            if (done) done_cnt++;
            if (busy && !axi_rready) rready_drop++;
            if (axis_tvalid && axis_tready) begin
                if (exp_s.size() == 0) chk("stream_unexpected", 1, 0);
                else begin
                    e = exp_s.pop_front();
                    chk("tdata", axis_tdata, e.d);
                    chk("tuser", axis_tuser, e.u);
                    chk("tlast", axis_tlast, e.l);
                end
            end
        end
    end

    task automatic start_frame(input logic [28:0] b, input int f, input int l);
        @(posedge clock); #1;
        base_addr = b; frame_words = 24'(f); line_words = 16'(l);
        start = 1'b1; frame_beat = 0; done_cnt = 0; rready_drop = 0;
        push_frame(b, f, l);
        @(posedge clock); #1;
        start = 1'b0;
        base_addr = '1; frame_words = 24'd7; line_words = 16'd3;
        @(negedge clock);
        chk("busy_after_start", busy, 1);
        chk("error_cleared_on_start", error, 0);
        chk("arvalid_1cyc_after_start", axi_arvalid, 0);
        @(negedge clock);
        chk("arvalid_2cyc_after_start", axi_arvalid, 1);
    endtask

    task automatic wait_done(input int budget, input logic exp_err);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (done_cnt > 0) break;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        else chk("error_at_done", error, exp_err);
        repeat (5) @(posedge clock);
        #1;
        chk("done_once", done_cnt, 1);
        chk("busy_after_done", busy, 0);
        chk("stream_drained", exp_s.size(), 0);
        chk("ar_all_seen", exp_ar.size(), 0);
        chk("rready_held", rready_drop, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int ar0, r0;
        rst = 1'b1; start = 1'b0; base_addr = '0; frame_words = '0; line_words = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_outputs", {axi_arvalid, axi_rready, axis_tvalid, axis_tuser, axis_tlast,
                            busy, done, error}, 0);
        chk("rst_tdata", axis_tdata, 0);
        chk("rst_araddr_arlen", {axi_araddr, axi_arlen}, 0);
        chk("arid", axi_arid, 0);
        chk("arsize", axi_arsize, 5);
        chk("arburst", axi_arburst, 1);
        @(posedge clock); #1;
        rst = 1'b0;

        // Multi-burst frame with partial last line, stream backpressure and R gaps
        tready_mode = 1; rgap = 1;
        push_ar_model(0, 300);
        start_frame(29'h0, 300, 40);
        repeat (40) @(posedge clock);
        #1;
        base_addr = 29'h5000; frame_words = 24'd5; line_words = 16'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(3000, 1'b0);

        // 4KB page split
        tready_mode = 0; rgap = 0;
        exp_ar.push_back('{addr: 29'hF80, len: 8'd3});
        exp_ar.push_back('{addr: 29'h1000, len: 8'd5});
        start_frame(29'hF80, 10, 4);
        wait_done(500, 1'b0);

        // Stream stalled: AR issue stops once the whole FIFO is reserved
        tready_mode = 2;
        push_ar_model(0, 2048);
        ar0 = n_ar; r0 = r_total;
        start_frame(29'h0, 2048, 256);
        repeat (1500) @(posedge clock);
        #1;
        chk("ar_count_when_full", n_ar - ar0, 4);
        chk("beats_when_full", r_total - r0, 512);
        tready_mode = 0;
        wait_done(5000, 1'b0);

        // Error response on beat 5
        err_beat = 5;
        push_ar_model(32'h100, 20);
        start_frame(29'h100, 20, 8);
        wait_done(500, 1'b1);
        err_beat = -1;

        // rlast early on beat 62 of a 128-beat burst
        early_last = 62;
        push_ar_model(0, 128);
        start_frame(29'h0, 128, 128);
        wait_done(800, 1'b1);
        early_last = -1;

        // Reset in the middle of a burst, then re-read the same frame
        push_ar_model(32'h2000, 256);
        r0 = r_total;
        start_frame(29'h2000, 256, 64);
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            if (r_total - r0 >= 20) break;
        end
        chk("beats_before_reset", (r_total - r0 >= 20), 1);
        rst = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_mid_outputs", {axi_arvalid, axi_rready, axis_tvalid, axis_tuser, axis_tlast,
                                busy, done, error}, 0);
        @(posedge clock); #1;
        rst = 1'b0;
        exp_s.delete();
        exp_ar.delete();
        push_ar_model(32'h2000, 256);
        start_frame(29'h2000, 256, 64);
        wait_done(1500, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
